// File: rtl/id_ex_stage_pkg.sv
// Shared decode/execute definitions: control-bundle layout and register specifier type.
// The decoder, the ID/EX stage and EX all index the control bundle through these constants.
package id_ex_stage_pkg;

    localparam int unsigned CTRL_W = 12;

    // Control-bundle bit positions
    localparam int unsigned REGWRITE  = 0;
    localparam int unsigned MEMREAD   = 1;
    localparam int unsigned MEMWRITE  = 2;
    localparam int unsigned MEMTOREG  = 3;
    localparam int unsigned ALUSRC    = 4;
    localparam int unsigned REGDST    = 5;
    localparam int unsigned ALUOP_LSB = 6;
    localparam int unsigned ALUOP_W   = 4;
    localparam int unsigned BRANCH    = 10;
    localparam int unsigned JUMP      = 11;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [ALUOP_W-1:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluAnd   = 4'd2,
        AluOr    = 4'd3,
        AluXor   = 4'd4,
        AluSlt   = 4'd5,
        AluSll   = 4'd6,
        AluSrl   = 4'd7,
        AluFunct = 4'd8
    } alu_op_e;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detector: a load sitting in EX whose destination is read
// by the instruction in decode forces a one-cycle bubble.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic     In_Valid,
    input  reg_idx_t In_Rs,
    input  reg_idx_t In_Rt,
    input  logic     In_Rs_Used,
    input  logic     In_Rt_Used,
    input  logic     Ex_Valid,
    input  logic     Ex_Mem_Read,
    input  reg_idx_t Ex_Rt,
    input  logic     Flush,
    input  logic     Ext_Stall,
    output logic     Hazard_Stall
);

    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    // $0 is hardwired, so a load targeting it can never create a dependency.
    assign ex_is_load = Ex_Valid & Ex_Mem_Read & (Ex_Rt != 5'd0);
    assign rs_match   = In_Rs_Used & (In_Rs == Ex_Rt);
    assign rt_match   = In_Rt_Used & (In_Rt == Ex_Rt);

    assign Hazard_Stall = In_Valid & ex_is_load & (rs_match | rt_match) & ~Flush & ~Ext_Stall;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and saturating stall/flush counters.
module id_ex_stage #(
    parameter int unsigned CTRL_W = id_ex_stage_pkg::CTRL_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              In_Valid,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [4:0]        In_Rs,
    input  logic [4:0]        In_Rt,
    input  logic [4:0]        In_Rd,
    input  logic              In_Rs_Used,
    input  logic              In_Rt_Used,
    input  logic [31:0]       In_Rd1,
    input  logic [31:0]       In_Rd2,
    input  logic [31:0]       In_Imm,
    input  logic [31:0]       In_PC4,
    input  logic              Flush,
    input  logic              Ext_Stall,
    output logic              Out_Valid,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [4:0]        Out_Rs,
    output logic [4:0]        Out_Rt,
    output logic [4:0]        Out_Rd,
    output logic [31:0]       Out_Rd1,
    output logic [31:0]       Out_Rd2,
    output logic [31:0]       Out_Imm,
    output logic [31:0]       Out_PC4,
    output logic              Hazard_Stall,
    output logic [CNT_W-1:0]  Stall_Count,
    output logic [CNT_W-1:0]  Flush_Count
);

    import id_ex_stage_pkg::*;

    logic bubble;

    load_use_detect u_load_use_detect (
        .In_Valid     (In_Valid),
        .In_Rs        (In_Rs),
        .In_Rt        (In_Rt),
        .In_Rs_Used   (In_Rs_Used),
        .In_Rt_Used   (In_Rt_Used),
        .Ex_Valid     (Out_Valid),
        .Ex_Mem_Read  (Out_Ctrl[MEMREAD]),
        .Ex_Rt        (Out_Rt),
        .Flush        (Flush),
        .Ext_Stall    (Ext_Stall),
        .Hazard_Stall (Hazard_Stall)
    );

    assign bubble = Flush | Hazard_Stall;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Out_Valid   <= 1'b0;
            Out_Ctrl    <= '0;
            Out_Rs      <= '0;
            Out_Rt      <= '0;
            Out_Rd      <= '0;
            Out_Rd1     <= '0;
            Out_Rd2     <= '0;
            Out_Imm     <= '0;
            Out_PC4     <= '0;
            Stall_Count <= '0;
            Flush_Count <= '0;
        end else if (!Ext_Stall) begin
            // Flush is deliberately ignored while frozen; the branch unit keeps it asserted.
            if (bubble) begin
                Out_Valid <= 1'b0;
                Out_Ctrl  <= '0;
                Out_Rs    <= '0;
                Out_Rt    <= '0;
                Out_Rd    <= '0;
                Out_Rd1   <= '0;
                Out_Rd2   <= '0;
                Out_Imm   <= '0;
                Out_PC4   <= '0;
            end else begin
                Out_Valid <= In_Valid;
                Out_Ctrl  <= In_Valid ? In_Ctrl : '0;
                Out_Rs    <= In_Rs;
                Out_Rt    <= In_Rt;
                Out_Rd    <= In_Rd;
                Out_Rd1   <= In_Rd1;
                Out_Rd2   <= In_Rd2;
                Out_Imm   <= In_Imm;
                Out_PC4   <= In_PC4;
            end
            if (Hazard_Stall && (Stall_Count != '1)) begin
                Stall_Count <= Stall_Count + CNT_W'(1);
            end
            if (Flush && (Flush_Count != '1)) begin
                Flush_Count <= Flush_Count + CNT_W'(1);
            end
        end
    end

endmodule
